seq_timing_ctrl: RTL

Instruction-cycle timing sequencer for the processor model. Holds a 3-bit sequence count (T-state) and an enable, run/halt control and a retired-instruction counter. sc drives the 3-to-8 decoder's select input and sc_en drives its enable, so the decoder outputs one-hot timing signals T0..T7 to control logic. clr (sequence clear from control logic) ends an instruction early.

---
 rtl/seq_timing_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/seq_timing_ctrl.sv
// Instruction-cycle T-state sequencer with run/halt control and retired count.
// Optional single-step gating when SEQ_SINGLE_STEP_EN is defined.
module seq_timing_ctrl #(
   parameter int unsigned LAST_T = 7,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             clr,
   input  logic             hold,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   output logic [2:0]       sc,
   output logic             sc_en,
   output logic             running,
   output logic             halted,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;

   localparam logic [2:0]       LAST = 3'(LAST_T);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [1:0] state;
   logic       active;
   logic       stall;
   logic       fin;

`ifdef SEQ_SINGLE_STEP_EN
   // A non-step cycle in step mode is indistinguishable from a hold cycle.
   assign stall = hold | (step_mode & ~step);
`else
   assign stall = hold;
`endif

   assign active     = (state == RUN) || (state == DRAIN);
   assign fin        = active & ~stall & (clr | (sc == LAST));
   assign instr_done = fin;
   assign sc_en      = active;
   assign running    = active;
   assign halted     = (state == HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sc        <= '0;
         instr_cnt <= '0;
      end else begin
         if (fin && (instr_cnt != '1))
            instr_cnt <= instr_cnt + ONE;
         case (state)
            IDLE, HALTED: begin
               sc <= '0;
               if (start)
                  state <= RUN;
            end
            RUN, DRAIN: begin
               if (!stall) begin
                  if (fin) begin
                     sc <= '0;
                     if ((state == DRAIN) || halt_req)
                        state <= HALTED;
                  end else begin
                     sc <= sc + 3'd1;
                     if (halt_req)
                        state <= DRAIN;
                  end
               end
            end
            default: begin
               state <= IDLE;
               sc    <= '0;
            end
         endcase
      end
   end

endmodule
